// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared RV32M operation encodings, FSM states and datapath width
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    localparam int XLEN = 32;

    // Same encoding is driven by the main control unit onto md_operation.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative radix-2 RV32M multiply/divide unit (32 steps/op)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      md_operation,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e         r_state, w_state_next;
    md_op_e            r_op;
    logic              r_sign_a, r_sign_b;
    logic [4:0]        r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_oper;
    logic [XLEN-1:0]   r_result;

    // ---------------- accept-time decode ----------------
    logic            w_accept, w_is_div, w_a_signed, w_b_signed;
    logic            w_sign_a, w_sign_b, w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_res;

    assign w_accept   = (r_state == ST_IDLE) && start && !flush;
    assign w_is_div   = md_operation[2];
    assign w_a_signed = (md_operation == MD_MULH) || (md_operation == MD_MULHSU) ||
                        (md_operation == MD_DIV)  || (md_operation == MD_REM);
    assign w_b_signed = (md_operation == MD_MULH) || (md_operation == MD_DIV) ||
                        (md_operation == MD_REM);
    assign w_sign_a   = w_a_signed && operand_a[XLEN-1];
    assign w_sign_b   = w_b_signed && operand_b[XLEN-1];
    assign w_abs_a    = w_sign_a ? (~operand_a + 32'd1) : operand_a;
    assign w_abs_b    = w_sign_b ? (~operand_b + 32'd1) : operand_b;

    assign w_div_zero = w_is_div && (operand_b == '0);
    assign w_div_ovf  = ((md_operation == MD_DIV) || (md_operation == MD_REM)) &&
                        (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;

    // md_operation[1] separates REM/REMU from DIV/DIVU within the divide group.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = md_operation[1] ? operand_a : 32'hFFFF_FFFF;
        else if (w_div_ovf)
            w_special_res = md_operation[1] ? 32'h0000_0000 : 32'h8000_0000;
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     w_mul_sum, w_div_rem;
    logic [XLEN-1:0]   w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next;

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_oper} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient bits}, shift left.
    assign w_div_rem  = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge   = w_div_rem >= {1'b0, r_oper};
    assign w_div_diff = w_div_rem[XLEN-1:0] - r_oper;
    assign w_div_next = {(w_div_ge ? w_div_diff : w_div_rem[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_div_ge};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    // ---------------- sign fix on the final step ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_final;

    assign w_prod = (r_sign_a ^ r_sign_b) ? (~w_acc_next + 64'd1) : w_acc_next;
    assign w_quot = (r_sign_a ^ r_sign_b) ? (~w_acc_next[XLEN-1:0] + 32'd1)
                                          : w_acc_next[XLEN-1:0];
    assign w_rem  = r_sign_a ? (~w_acc_next[2*XLEN-1:XLEN] + 32'd1)
                             : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_prod[XLEN-1:0];
        case (r_op)
            MD_MUL:                       w_final = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_final = w_quot;
            default:                      w_final = w_rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == 5'd31) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) w_state_next = ST_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= MD_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_oper   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= md_op_e'(md_operation);
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_cnt    <= '0;
            r_acc    <= {32'd0, (w_is_div ? w_abs_a : w_abs_b)};
            r_oper   <= w_is_div ? w_abs_b : w_abs_a;
            if (w_special) r_result <= w_special_res;
        end else if ((r_state == ST_CALC) && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_result <= w_final;
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit with directed RV32M vectors
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  md_operation = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done;
    logic [31:0] result;

    mul_div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .md_operation (md_operation),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          at_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every done pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=0x%08h cyc=%0d, no done expected", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (result !== mon_e.res || cyc != mon_e.at_cyc) begin
                    errors++;
                    $display("FAIL %s: result=0x%08h at cyc %0d, expected 0x%08h at cyc %0d",
                             mon_e.name, result, cyc, mon_e.res, mon_e.at_cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request; returns in cycle 1 with operands scrambled.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push, input string name);
        exp_t t;
        md_operation = op;
        operand_a    = a;
        operand_b    = b;
        start        = 1'b1;
        if (push) begin
            t.res    = exp;
            t.at_cyc = cyc + lat;
            t.name   = name;
            sb.push_back(t);
        end
        @(posedge clk); #1;
        start        = 1'b0;
        operand_a    = $urandom();
        operand_b    = $urandom();
        md_operation = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=1 after 60 cycles, expected 0");
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min"});
        vecs.push_back('{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1"});
        vecs.push_back('{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max"});
        vecs.push_back('{MD_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33, "mul_shift"});
        vecs.push_back('{MD_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu_100_7"});
        vecs.push_back('{MD_REMU,   32'd100,       32'd7,         32'd2,         33, "remu_100_7"});
        vecs.push_back('{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2"});
        vecs.push_back('{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2"});
        vecs.push_back('{MD_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_m7"});
        vecs.push_back('{MD_REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         33, "rem_100_m7"});
        vecs.push_back('{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div_by_zero"});
        vecs.push_back('{MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by_zero"});
        vecs.push_back('{MD_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, 1,  "rem_by_zero"});
        vecs.push_back('{MD_REMU,   32'h8000_0001, 32'd0,         32'h8000_0001, 1,  "remu_by_zero"});
        vecs.push_back('{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_overflow"});
        vecs.push_back('{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_overflow"});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL with busy profile over cycles 1..34
        drive(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, "mul_7_m3");
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            check($sformatf("busy_mul_c%0d", k), 32'(busy), (k <= 33) ? 32'd1 : 32'd0);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1, vecs[i].name);
            wait_idle();
        end

        // Restart at cycle 5 must be ignored
        drive(MD_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1, "divu_restart_ignored");
        repeat (4) begin
            @(posedge clk); #1;
        end
        md_operation = MD_MUL;
        operand_a    = 32'd3;
        operand_b    = 32'd3;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Flush at cycle 10, restart at cycle 11
        drive(MD_DIVU, 32'd50, 32'd5, 32'd0, 0, 1'b0, "divu_flushed");
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_result_held", result, 32'd100);
        drive(MD_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1, "remu_after_flush");
        wait_idle();

        // Flush beats start in the same cycle
        md_operation = MD_DIVU;
        operand_a    = 32'd9;
        operand_b    = 32'd3;
        start        = 1'b1;
        flush        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_over_start_busy", 32'(busy), 32'd0);
        check("flush_over_start_result", result, 32'd2);

        // Reset at cycle 20
        drive(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 1'b0, "mulhu_reset");
        repeat (19) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        drive(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1, "divu_after_reset");
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
